kamus_lsu: RTL and testbench
============================

Name: kamus_lsu

Overview:
Parametrised load/store unit that succeeds the combinational MEM-stage data path. It accepts one load/store per handshake from EX and drives a request/grant/response data-memory bus with byte enables and lane alignment. It returns sign- or zero-extended load data and a completion pulse to WB. Misaligned accesses and bus timeouts are flagged without touching memory state; stall is exported to the pipeline.

Parameters:
DATA_W, 32, memory bus data width in bits; legal values are 32 or 64. BE_W = DATA_W/8 and OFF_W = log2(BE_W).
ADDR_W, 32, byte address width.
TIMEOUT_CYCLES, 64, maximum cycles from entering REQ to response before a bus error is raised; 0 disables the timeout.

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  EX presents an operation
ready_o  out  1  LSU can accept; valid_i&&ready_o is an accept
stall_o  out  1  equals valid_i && !ready_o
operation_i  in  5  kamus_pkg op code (LB, LH, LW, LBU, LHU, SB, SH, SW)
addr_i  in  ADDR_W  byte address (ALU result)
wdata_i  in  32  store data (rs2)
rd_addr_i  in  5  destination register
valid_o  out  1  one-cycle completion pulse to WB
rdata_o  out  32  extended load data; 0 for stores and faults
rd_addr_o  out  5  rd of the completed operation
misaligned_o  out  1  qualifies valid_o; address is misaligned
bus_err_o  out  1  qualifies valid_o; timeout expired
req_o  out  1  memory request
gnt_i  in  1  memory grant
we_o  out  1  1 = store
be_o  out  BE_W  byte enables
mem_addr_o  out  ADDR_W  bus-aligned address (low OFF_W bits = 0)
mem_wdata_o  out  DATA_W  lane-replicated store data
rvalid_i  in  1  memory response (loads and stores)
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset state: FSM=IDLE; ready_o=1; all other outputs=0, including req_o, we_o, be_o, mem_addr_o, mem_wdata_o, valid_o, rdata_o, rd_addr_o, misaligned_o, bus_err_o and the timeout counter.
- FSM states: IDLE, REQ, WAIT, RESP. ready_o=1 only in IDLE.
- IDLE, on accept: register op, offset=addr_i[OFF_W-1:0] and rd_addr_i.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to RESP with misaligned_o=1 and no bus activity.
  - Op not a load/store: go to RESP as a no-op with rdata_o=0.
  - Otherwise: go to REQ.
- REQ: req_o=1. mem_addr_o, we_o, be_o and mem_wdata_o are registered and held stable until gnt_i. On gnt_i=1, go to WAIT; req_o=0 from the next cycle.
- WAIT: on rvalid_i=1, capture load data and go to RESP.
- rvalid_i is ignored outside WAIT.
- RESP: valid_o=1 for exactly one cycle with rd_addr_o and flags, then return to IDLE. Outputs are registered. Minimum accept-to-valid_o latency is 4 cycles (accept, REQ with same-cycle gnt, WAIT with same-cycle rvalid, RESP).
- Byte enables:
  - SB/LB/LBU: 1<<offset.
  - SH/LH/LHU: 2'b11<<offset.
  - SW/LW: 4'hF<<offset.
- Store data: SB replicates wdata_i[7:0] across all lanes; SH replicates wdata_i[15:0]; SW replicates wdata_i[31:0] (twice for DATA_W=64).
- Load extraction: shift mem_rdata_i right by offset*8.
  - LB and LH sign-extend bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW takes the low 32 bits.
- Timeout: the counter starts at 0 on entry to REQ and increments in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to RESP with bus_err_o=1, req_o=0 and rdata_o=0.
  - A later stray rvalid_i is ignored.
- Reset mid-operation: all state returns to IDLE in the next cycle, req_o drops, and no valid_o is produced for the aborted op. A response arriving after reset is ignored.
- valid_i while busy: the input is not accepted; stall_o=1.

Test Plan:
1. DATA_W=32, LB at addr 0x103, mem_rdata_i=0x80FF_1234, gnt and rvalid each arrive one cycle late -> be_o=4'b1000, mem_addr_o=0x100, rdata_o=0xFFFF_FF80, valid_o 6 cycles after accept.
2. LHU at addr 0x102, rdata 0x8001_0000 -> rdata_o=0x0000_8001. LH at the same address -> rdata_o=0xFFFF_8001.
3. SH at addr 0x22, wdata_i=0xDEAD_BEEF -> we_o=1, be_o=4'b1100, mem_wdata_o=0xBEEF_BEEF; req_o held 3 cycles until gnt; valid_o with rdata_o=0.
4. LW at addr 0x6 -> no req_o ever asserted; valid_o one cycle after accept (2 cycles) with misaligned_o=1; stall_o=1 on a back-to-back valid_i in that cycle.
5. TIMEOUT_CYCLES=8, LW at 0x40, gnt given but rvalid_i never arrives -> bus_err_o with valid_o; a late rvalid_i in IDLE has no effect.
6. DATA_W=64, SW at 0x10C, wdata 0x1234_5678 -> mem_addr_o=0x108, be_o=8'hF0, mem_wdata_o=0x12345678_12345678. rst_i asserted while in WAIT -> IDLE next cycle, no valid_o.

Source files
------------

// File: rtl/kamus_lsu.sv
// Load/store unit: one op per EX handshake, drives a req/gnt/rvalid data bus with byte lanes,
// returns extended load data plus misaligned/timeout flags to WB.
module kamus_lsu #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  stall_o,
    input  logic [4:0]            operation_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            rd_addr_i,
    output logic                  valid_o,
    output logic [31:0]           rdata_o,
    output logic [4:0]            rd_addr_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic                  we_o,
    output logic [DATA_W/8-1:0]   be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [4:0] OP_LB  = 5'h10;
    localparam logic [4:0] OP_LH  = 5'h11;
    localparam logic [4:0] OP_LW  = 5'h12;
    localparam logic [4:0] OP_LBU = 5'h14;
    localparam logic [4:0] OP_LHU = 5'h15;
    localparam logic [4:0] OP_SB  = 5'h18;
    localparam logic [4:0] OP_SH  = 5'h19;
    localparam logic [4:0] OP_SW  = 5'h1A;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [4:0]           op_q;
    logic [OFF_W-1:0]     off_q;
    logic [4:0]           rd_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          rdata_q;
    logic                 mis_q, err_q, we_q;
    logic [BE_W-1:0]      be_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;

    logic                 accept, busy, tmo, resp_ok, tmo_hit;
    logic                 is_load, is_store, misal_in;
    logic [1:0]           size;
    logic [OFF_W-1:0]     off_in;
    logic [BE_W-1:0]      be_in;
    logic [DATA_W-1:0]    wdata_in;
    logic [DATA_W-1:0]    shifted;
    logic [31:0]          load_data;

    assign ready_o      = (state_q == StIdle);
    assign stall_o      = valid_i && !ready_o;
    assign accept       = valid_i && ready_o;
    assign req_o        = (state_q == StReq);
    assign valid_o      = (state_q == StResp);
    assign busy         = (state_q == StReq) || (state_q == StWait);
    assign tmo          = (TIMEOUT_CYCLES != 0) && busy &&
                          (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // A response in the last WAIT cycle still completes normally.
    assign resp_ok      = (state_q == StWait) && rvalid_i;
    assign tmo_hit      = tmo && !resp_ok;
    assign off_in       = addr_i[OFF_W-1:0];

    assign rdata_o      = rdata_q;
    assign rd_addr_o    = rd_q;
    assign misaligned_o = mis_q;
    assign bus_err_o    = err_q;
    assign we_o         = we_q;
    assign be_o         = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;

    // size: 0 byte, 1 half, 2 word
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = 2'd0;
        case (operation_i)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; size = 2'd1; end
            OP_LW:         begin is_load = 1'b1; size = 2'd2; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; size = 2'd1; end
            OP_SW:         begin is_store = 1'b1; size = 2'd2; end
            default:       ;
        endcase
        misal_in = ((size == 2'd1) && addr_i[0]) || ((size == 2'd2) && (addr_i[1:0] != 2'b00));
        case (size)
            2'd1:    begin
                be_in    = BE_W'(2'b11) << off_in;
                wdata_in = {(BE_W/2){wdata_i[15:0]}};
            end
            2'd2:    begin
                be_in    = BE_W'(4'hF) << off_in;
                wdata_in = {(BE_W/4){wdata_i}};
            end
            default: begin
                be_in    = BE_W'(1) << off_in;
                wdata_in = {BE_W{wdata_i[7:0]}};
            end
        endcase
    end

    always_comb begin
        shifted = mem_rdata_i >> {off_q, 3'b000};
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LBU:  load_data = {24'd0, shifted[7:0]};
            OP_LHU:  load_data = {16'd0, shifted[15:0]};
            OP_LW:   load_data = shifted[31:0];
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = (misal_in || !(is_load || is_store)) ? StResp : StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (tmo_hit)    state_d = StResp;
                else if (gnt_i) state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (resp_ok || tmo_hit) state_d = StResp;
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= operation_i;
                off_q   <= off_in;
                rd_q    <= rd_addr_i;
                mis_q   <= misal_in;
                err_q   <= 1'b0;
                rdata_q <= '0;
                if (state_d == StReq) begin
                    we_q    <= is_store;
                    be_q    <= be_in;
                    addr_q  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_q <= wdata_in;
                end
            end
            if (resp_ok && !we_q) rdata_q <= load_data;
            if (tmo_hit)          err_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_kamus_lsu.sv
// Directed bench for kamus_lsu: a 32-bit instance with an 8-cycle timeout and a 64-bit instance.
module tb_kamus_lsu;
    localparam logic [4:0] OP_LB  = 5'h10;
    localparam logic [4:0] OP_LH  = 5'h11;
    localparam logic [4:0] OP_LW  = 5'h12;
    localparam logic [4:0] OP_LBU = 5'h14;
    localparam logic [4:0] OP_LHU = 5'h15;
    localparam logic [4:0] OP_SB  = 5'h18;
    localparam logic [4:0] OP_SH  = 5'h19;
    localparam logic [4:0] OP_SW  = 5'h1A;

    typedef struct {
        bit          w64;
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [63:0] mem;
        int          gdly;
        int          rdly;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic        e_we;
        logic [63:0] e_wdata;
        int          e_req;
        logic [31:0] e_rdata;
        logic        e_mis;
        logic        e_err;
        int          e_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst32 = 1'b1, rst64 = 1'b1;
    bit          sel = 1'b0;
    logic        valid = 1'b0, gnt = 1'b0, rvalid = 1'b0;
    logic [4:0]  op = '0, rd = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [63:0] mrdata = '0;

    logic        ready32, stall32, valid_o32, mis32, err32, req32, we32;
    logic [31:0] rdata32, maddr32;
    logic [4:0]  rd32;
    logic [3:0]  be32;
    logic [31:0] mwd32;
    logic        ready64, stall64, valid_o64, mis64, err64, req64, we64;
    logic [31:0] rdata64, maddr64;
    logic [4:0]  rd64;
    logic [7:0]  be64;
    logic [63:0] mwd64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kamus_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) u_d32 (
        .clk_i(clk), .rst_i(rst32), .valid_i(valid && !sel), .ready_o(ready32),
        .stall_o(stall32), .operation_i(op), .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd),
        .valid_o(valid_o32), .rdata_o(rdata32), .rd_addr_o(rd32), .misaligned_o(mis32),
        .bus_err_o(err32), .req_o(req32), .gnt_i(gnt), .we_o(we32), .be_o(be32),
        .mem_addr_o(maddr32), .mem_wdata_o(mwd32), .rvalid_i(rvalid),
        .mem_rdata_i(mrdata[31:0])
    );

    kamus_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(64)) u_d64 (
        .clk_i(clk), .rst_i(rst64), .valid_i(valid && sel), .ready_o(ready64),
        .stall_o(stall64), .operation_i(op), .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd),
        .valid_o(valid_o64), .rdata_o(rdata64), .rd_addr_o(rd64), .misaligned_o(mis64),
        .bus_err_o(err64), .req_o(req64), .gnt_i(gnt), .we_o(we64), .be_o(be64),
        .mem_addr_o(maddr64), .mem_wdata_o(mwd64), .rvalid_i(rvalid), .mem_rdata_i(mrdata)
    );

    logic        ready_m, stall_m, valid_m, mis_m, err_m, req_m, we_m;
    logic [31:0] rdata_m, maddr_m;
    logic [4:0]  rd_m;
    logic [7:0]  be_m;
    logic [63:0] mwd_m;

    always_comb begin
        ready_m = sel ? ready64   : ready32;
        stall_m = sel ? stall64   : stall32;
        valid_m = sel ? valid_o64 : valid_o32;
        mis_m   = sel ? mis64     : mis32;
        err_m   = sel ? err64     : err32;
        req_m   = sel ? req64     : req32;
        we_m    = sel ? we64      : we32;
        rdata_m = sel ? rdata64   : rdata32;
        maddr_m = sel ? maddr64   : maddr32;
        rd_m    = sel ? rd64      : rd32;
        be_m    = sel ? be64      : {4'b0, be32};
        mwd_m   = sel ? mwd64     : {32'b0, mwd32};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit w64, logic [4:0] o, logic [31:0] a, logic [31:0] wd,
                                logic [4:0] r, logic [63:0] m, int gd, int rdl,
                                logic [31:0] ea, logic [7:0] eb, logic ew, logic [63:0] ewd,
                                int ereq, logic [31:0] erd, logic emis, logic eerr, int elat);
        vec_t v;
        v.w64 = w64; v.op = o; v.addr = a; v.wdata = wd; v.rd = r; v.mem = m;
        v.gdly = gd; v.rdly = rdl; v.e_addr = ea; v.e_be = eb; v.e_we = ew; v.e_wdata = ewd;
        v.e_req = ereq; v.e_rdata = erd; v.e_mis = emis; v.e_err = eerr; v.e_lat = elat;
        return v;
    endfunction

    // Present one op, play the memory side with the given gnt/rvalid delays, check everything.
    task automatic run(input vec_t v);
        int req_cycles = 0;
        int wait_cycles = 0;
        int lat = -1;
        bit granted = 1'b0;
        sel = v.w64;
        op = v.op; addr = v.addr; wdata = v.wdata; rd = v.rd; valid = 1'b1;
        chk("accept_ready", 64'(ready_m), 64'd1);
        step();
        valid = 1'b0;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            gnt = 1'b0; rvalid = 1'b0; mrdata = '0;
            if (valid_m) begin
                lat = c;
                chk("latency", 64'(c), 64'(v.e_lat));
                chk("rdata", 64'(rdata_m), 64'(v.e_rdata));
                chk("rd_addr", 64'(rd_m), 64'(v.rd));
                chk("misaligned", 64'(mis_m), 64'(v.e_mis));
                chk("bus_err", 64'(err_m), 64'(v.e_err));
            end else if (req_m) begin
                chk("req_addr", 64'(maddr_m), 64'(v.e_addr));
                chk("req_be", 64'(be_m), 64'(v.e_be));
                if (req_cycles == 0) begin
                    chk("req_we", 64'(we_m), 64'(v.e_we));
                    if (v.e_we) chk("req_wdata", mwd_m, v.e_wdata);
                end
                req_cycles++;
                if (req_cycles > v.gdly) begin gnt = 1'b1; granted = 1'b1; end
            end else if (granted) begin
                wait_cycles++;
                if (wait_cycles > v.rdly) begin rvalid = 1'b1; mrdata = v.mem; end
            end
            step();
        end
        gnt = 1'b0; rvalid = 1'b0;
        if (lat < 0) chk("valid_timeout", 64'd0, 64'd1);
        chk("req_cycles", 64'(req_cycles), 64'(v.e_req));
        chk("pulse_end", 64'({valid_m, ready_m}), 64'b01);
        // A stray response while idle must be ignored.
        rvalid = 1'b1; mrdata = v.mem;
        step();
        rvalid = 1'b0; mrdata = '0;
        chk("stray_rvalid", 64'({valid_m, req_m, ready_m}), 64'b001);
    endtask

    vec_t vq[$];

    initial begin
        vq.push_back(mk(0, OP_LB,  32'h103, 32'h0, 5'd7, 64'h80FF_1234, 1, 1,
                        32'h100, 8'h08, 0, 64'h0, 2, 32'hFFFF_FF80, 0, 0, 5));
        vq.push_back(mk(0, OP_LHU, 32'h102, 32'h0, 5'd8, 64'h8001_0000, 0, 0,
                        32'h100, 8'h0C, 0, 64'h0, 1, 32'h0000_8001, 0, 0, 3));
        vq.push_back(mk(0, OP_LH,  32'h102, 32'h0, 5'd9, 64'h8001_0000, 0, 0,
                        32'h100, 8'h0C, 0, 64'h0, 1, 32'hFFFF_8001, 0, 0, 3));
        vq.push_back(mk(0, OP_SH,  32'h22, 32'hDEAD_BEEF, 5'd3, 64'hFFFF_FFFF, 2, 0,
                        32'h20, 8'h0C, 1, 64'hBEEF_BEEF, 3, 32'h0, 0, 0, 5));
        vq.push_back(mk(0, OP_LW,  32'h6, 32'h0, 5'd4, 64'h0, 0, 0,
                        32'h0, 8'h0, 0, 64'h0, 0, 32'h0, 1, 0, 1));
        vq.push_back(mk(0, OP_LW,  32'h40, 32'h0, 5'd5, 64'h1234_5678, 0, 99,
                        32'h40, 8'h0F, 0, 64'h0, 1, 32'h0, 0, 1, 9));
        vq.push_back(mk(0, OP_LBU, 32'h101, 32'h0, 5'd10, 64'h0000_8000, 0, 0,
                        32'h100, 8'h02, 0, 64'h0, 1, 32'h0000_0080, 0, 0, 3));
        vq.push_back(mk(0, OP_SB,  32'h3, 32'h0000_005A, 5'd11, 64'h0, 0, 0,
                        32'h0, 8'h08, 1, 64'h5A5A_5A5A, 1, 32'h0, 0, 0, 3));
        vq.push_back(mk(0, OP_SW,  32'h8, 32'hCAFE_F00D, 5'd12, 64'h0, 0, 2,
                        32'h8, 8'h0F, 1, 64'hCAFE_F00D, 1, 32'h0, 0, 0, 5));
        vq.push_back(mk(0, OP_LH,  32'h101, 32'h0, 5'd13, 64'h0, 0, 0,
                        32'h0, 8'h0, 0, 64'h0, 0, 32'h0, 1, 0, 1));
        vq.push_back(mk(0, 5'h00,  32'h7, 32'h0, 5'd14, 64'h0, 0, 0,
                        32'h0, 8'h0, 0, 64'h0, 0, 32'h0, 0, 0, 1));
        vq.push_back(mk(1, OP_LHU, 32'h10E, 32'h0, 5'd15, 64'h8001_0000_0000_0000, 0, 0,
                        32'h108, 8'hC0, 0, 64'h0, 1, 32'h0000_8001, 0, 0, 3));
        vq.push_back(mk(1, OP_LB,  32'h105, 32'h0, 5'd16, 64'h0000_8000_0000_0000, 1, 0,
                        32'h100, 8'h20, 0, 64'h0, 2, 32'hFFFF_FF80, 0, 0, 4));
        vq.push_back(mk(1, OP_LW,  32'h10C, 32'h0, 5'd17, 64'hAABB_CCDD_1122_3344, 0, 1,
                        32'h108, 8'hF0, 0, 64'h0, 1, 32'hAABB_CCDD, 0, 0, 4));
        vq.push_back(mk(1, OP_SH,  32'h10A, 32'hABCD_1234, 5'd18, 64'h0, 0, 0,
                        32'h108, 8'h0C, 1, 64'h1234_1234_1234_1234, 1, 32'h0, 0, 0, 3));
        vq.push_back(mk(1, OP_LW,  32'h102, 32'h0, 5'd19, 64'h0, 0, 0,
                        32'h0, 8'h0, 0, 64'h0, 0, 32'h0, 1, 0, 1));

        step(); step();
        rst32 = 1'b0; rst64 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            chk("rst_ready", 64'(ready_m), 64'd1);
            chk("rst_ctl", 64'({valid_m, req_m, we_m, mis_m, err_m, stall_m}), 64'd0);
            chk("rst_data", 64'({be_m, maddr_m, rdata_m, rd_m}), 64'd0);
            chk("rst_wdata", mwd_m, 64'd0);
        end

        foreach (vq[i]) run(vq[i]);

        // Back-to-back valid_i while the misaligned response is out.
        sel = 1'b0;
        op = OP_LW; addr = 32'h6; rd = 5'd2; valid = 1'b1;
        step();
        op = OP_LB; addr = 32'h0;
        chk("b2b_stall", 64'({stall_m, ready_m}), 64'b10);
        chk("b2b_resp", 64'({valid_m, mis_m, req_m}), 64'b110);
        step();
        valid = 1'b0;
        chk("b2b_idle", 64'({valid_m, ready_m, stall_m}), 64'b010);
        step();
        chk("b2b_no_accept", 64'({req_m, valid_m, ready_m}), 64'b001);

        // Reset while waiting for the response on the 64-bit instance.
        sel = 1'b1;
        op = OP_SW; addr = 32'h10C; wdata = 32'h1234_5678; rd = 5'd6; valid = 1'b1;
        step();
        valid = 1'b0;
        chk("sw64_req", 64'(req_m), 64'd1);
        chk("sw64_addr", 64'(maddr_m), 64'h108);
        chk("sw64_be", 64'(be_m), 64'hF0);
        chk("sw64_we", 64'(we_m), 64'd1);
        chk("sw64_wdata", mwd_m, 64'h1234_5678_1234_5678);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("sw64_wait", 64'({req_m, ready_m, valid_m}), 64'b000);
        rst64 = 1'b1;
        step();
        rst64 = 1'b0;
        chk("rst_mid_ctl", 64'({ready_m, req_m, valid_m, we_m}), 64'b1000);
        chk("rst_mid_bus", 64'({be_m, maddr_m}), 64'd0);
        rvalid = 1'b1; mrdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        rvalid = 1'b0;
        chk("rst_late_rvalid", 64'({valid_m, ready_m, rdata_m}), {31'd0, 1'b0, 1'b1, 32'd0});
        step();
        chk("rst_quiet", 64'({valid_m, req_m}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
